// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the four byte requesters, the shared UART transmitter and uart_tx_arbiter.
// slave is the arbiter's view of the bundle; master is the environment's view.
interface uart_tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  lock;
  logic [3:0]  ack;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        err;

  modport slave (
    input  req, din, lock, tx_busy,
    output ack, tx_data, tx_start, grant_id, active, err
  );

  modport master (
    output req, din, lock, tx_busy,
    input  ack, tx_data, tx_start, grant_id, active, err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding four byte requesters into one UART transmitter, with a start-timeout error flag.
// Optional packet lock (re-grant of a locked requester) is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int START_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rstn,
  uart_tx_arbiter_if.slave  bus
);

  localparam int CW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [1:0]      r_ptr;
  logic [1:0]      r_grant;
  logic [7:0]      r_tx_data;
  logic [3:0]      r_ack;
  logic            r_tx_start;
  logic            r_active;
  logic            r_err;
  logic [CW-1:0]   r_cnt;

  logic [1:0]      w_win;
  logic            w_found;
  logic [1:0]      w_idx;
  logic [7:0]      w_byte;
  logic [CW-1:0]   w_cnt_nxt;

  // Search starts one past the last granted index so every requester gets a turn.
  always_comb begin
    w_win   = r_ptr;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      w_idx = r_ptr + i[1:0];
      if (!w_found && bus.req[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
`ifdef UART_ARB_LOCK_EN
    if (bus.lock[r_grant] && bus.req[r_grant]) begin
      w_win = r_grant;
    end
`endif
  end

`ifndef UART_ARB_LOCK_EN
  logic w_unused_lock;
  assign w_unused_lock = ^bus.lock;
`endif

  assign w_byte    = bus.din[{w_win, 3'b000} +: 8];
  assign w_cnt_nxt = r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_ptr      <= 2'd3;
      r_grant    <= '0;
      r_tx_data  <= '0;
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      r_active   <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // A frame still on the wire defers arbitration.
          if (|bus.req && !bus.tx_busy) begin
            r_grant    <= w_win;
            r_tx_data  <= w_byte;
            r_ack      <= 4'(4'b0001 << w_win);
            r_tx_start <= 1'b1;
            r_active   <= 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          r_ack      <= '0;
          r_tx_start <= 1'b0;
          r_ptr      <= r_grant;
          r_cnt      <= '0;
          r_state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            r_cnt   <= '0;
            r_state <= WAIT_DONE;
          end else if (w_cnt_nxt == CW'(START_TIMEOUT)) begin
            r_cnt    <= '0;
            r_err    <= 1'b1;
            r_active <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            r_active <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack      = r_ack;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_start = r_tx_start;
  assign bus.grant_id = r_grant;
  assign bus.active   = r_active;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; the transmitter's tx_busy is driven by hand.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rstn;
  int   n_tests = 0;
  int   n_fail  = 0;

  uart_tx_arbiter_if u_if ();

  uart_tx_arbiter #(.START_TIMEOUT(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (u_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn         = 1'b0;
    u_if.req     = '0;
    u_if.din     = '0;
    u_if.lock    = '0;
    u_if.tx_busy = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  // Plays one transmitter frame starting in the START cycle; ends in IDLE. Counts stray strobes.
  task automatic serve_frame(input int n, output int starts);
    starts = 0;
    u_if.tx_busy = 1'b1;
    repeat (n + 1) begin
      step();
      if (u_if.tx_start) starts++;
    end
    u_if.tx_busy = 1'b0;
    step();
    if (u_if.tx_start) starts++;
  endtask

  task automatic test_reset();
    logic [16:0] got;
    u_if.req = '0; u_if.din = '0; u_if.lock = '0; u_if.tx_busy = 1'b0;
    rstn = 1'b0;
    #1;
    got = {u_if.ack, u_if.tx_start, u_if.tx_data, u_if.grant_id, u_if.active, u_if.err};
    n_tests++;
    if (got !== 17'h0) begin
      n_fail++; $display("FAIL reset_async: got %h want %h", got, 17'h0);
    end
    step();
    step();
    got = {u_if.ack, u_if.tx_start, u_if.tx_data, u_if.grant_id, u_if.active, u_if.err};
    n_tests++;
    if (got !== 17'h0) begin
      n_fail++; $display("FAIL reset_held: got %h want %h", got, 17'h0);
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [15:0] got;
    int s;
    u_if.din = 32'h0000_0048;
    u_if.req = 4'b0001;
    step();
    got = {u_if.ack, u_if.tx_start, u_if.tx_data, u_if.grant_id, u_if.active};
    n_tests++;
    if (got !== {4'b0001, 1'b1, 8'h48, 2'd0, 1'b1}) begin
      n_fail++; $display("FAIL single_issue: got %h want %h", got, {4'b0001, 1'b1, 8'h48, 2'd0, 1'b1});
    end
    u_if.req = '0;
    serve_frame(2, s);
    n_tests++;
    if (s !== 0) begin
      n_fail++; $display("FAIL single_extra_start: got %0d want 0", s);
    end
    n_tests++;
    if ({u_if.active, u_if.tx_data} !== {1'b0, 8'h48}) begin
      n_fail++; $display("FAIL single_idle_hold: got %h want %h", {u_if.active, u_if.tx_data}, {1'b0, 8'h48});
    end
  endtask

  task automatic test_round_robin();
    int         exp_g [5];
    logic [7:0] exp_d [5];
    logic [14:0] got, want;
    int s;
    exp_g = '{0, 1, 2, 3, 0};
    exp_d = '{8'h65, 8'h6C, 8'h6F, 8'h21, 8'h65};
    do_reset();
    u_if.din = 32'h216F_6C65;
    u_if.req = 4'hF;
    step();
    for (int k = 0; k < 5; k++) begin
      want = {2'(exp_g[k]), exp_d[k], 4'(4'b0001 << exp_g[k]), 1'b1};
      got  = {u_if.grant_id, u_if.tx_data, u_if.ack, u_if.tx_start};
      n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL rr_grant%0d: got %h want %h", k, got, want);
      end
      serve_frame(3, s);
      n_tests++;
      if (s !== 0) begin
        n_fail++; $display("FAIL rr_one_start%0d: got %0d want 0", k, s);
      end
      if (k < 4) step();
    end
    u_if.req = '0;
    step();
  endtask

  task automatic test_busy_defer();
    int s;
    do_reset();
    u_if.tx_busy = 1'b1;
    u_if.din = 32'h005A_0000;
    u_if.req = 4'b0100;
    step();
    step();
    n_tests++;
    if ({u_if.tx_start, u_if.active, u_if.ack} !== 6'b0) begin
      n_fail++; $display("FAIL defer_held: got %b want %b", {u_if.tx_start, u_if.active, u_if.ack}, 6'b0);
    end
    u_if.tx_busy = 1'b0;
    step();
    n_tests++;
    if ({u_if.tx_start, u_if.grant_id, u_if.tx_data} !== {1'b1, 2'd2, 8'h5A}) begin
      n_fail++; $display("FAIL defer_release: got %h want %h", {u_if.tx_start, u_if.grant_id, u_if.tx_data}, {1'b1, 2'd2, 8'h5A});
    end
    u_if.req = '0;
    serve_frame(1, s);
  endtask

  task automatic test_timeout();
    int s;
    do_reset();
    u_if.din = 32'h0000_AB77;
    u_if.req = 4'b0001;
    step();
    n_tests++;
    if (u_if.tx_start !== 1'b1) begin
      n_fail++; $display("FAIL to_start: got %b want 1", u_if.tx_start);
    end
    u_if.req = '0;
    repeat (16) step();
    n_tests++;
    if ({u_if.err, u_if.active} !== 2'b01) begin
      n_fail++; $display("FAIL to_before: got %b want 01", {u_if.err, u_if.active});
    end
    step();
    n_tests++;
    if ({u_if.err, u_if.active} !== 2'b10) begin
      n_fail++; $display("FAIL to_fire: got %b want 10", {u_if.err, u_if.active});
    end
    repeat (3) step();
    u_if.req = 4'b0010;
    step();
    n_tests++;
    if ({u_if.err, u_if.tx_start, u_if.tx_data} !== {1'b1, 1'b1, 8'hAB}) begin
      n_fail++; $display("FAIL to_after: got %h want %h", {u_if.err, u_if.tx_start, u_if.tx_data}, {1'b1, 1'b1, 8'hAB});
    end
    u_if.req = '0;
    serve_frame(2, s);
    n_tests++;
    if (u_if.err !== 1'b1) begin
      n_fail++; $display("FAIL to_sticky: got %b want 1", u_if.err);
    end
  endtask

  task automatic test_lock();
    int exp_l [5];
    int s;
`ifdef UART_ARB_LOCK_EN
    exp_l = '{1, 2, 2, 2, 1};
`else
    exp_l = '{1, 2, 1, 2, 1};
`endif
    do_reset();
    u_if.din  = 32'h00C2_C100;
    u_if.lock = 4'b0100;
    u_if.req  = 4'b0110;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) u_if.lock = 4'b0000;
      step();
      n_tests++;
      if ({u_if.tx_start, u_if.grant_id} !== {1'b1, 2'(exp_l[k])}) begin
        n_fail++; $display("FAIL lock_grant%0d: got %h want %h", k, {u_if.tx_start, u_if.grant_id}, {1'b1, 2'(exp_l[k])});
      end
      serve_frame(2, s);
    end
    u_if.req = '0;
    u_if.lock = '0;
    step();
  endtask

  task automatic test_reset_mid();
    logic [16:0] got;
    do_reset();
    u_if.din = 32'h3300_AA11;
    u_if.req = 4'b0010;
    step();
    u_if.req = '0;
    u_if.tx_busy = 1'b1;
    step();
    step();
    n_tests++;
    if ({u_if.active, u_if.grant_id} !== {1'b1, 2'd1}) begin
      n_fail++; $display("FAIL rmid_in_frame: got %h want %h", {u_if.active, u_if.grant_id}, {1'b1, 2'd1});
    end
    u_if.req = 4'b1001;
    #2 rstn = 1'b0;
    #1;
    got = {u_if.ack, u_if.tx_start, u_if.tx_data, u_if.grant_id, u_if.active, u_if.err};
    n_tests++;
    if (got !== 17'h0) begin
      n_fail++; $display("FAIL rmid_async: got %h want %h", got, 17'h0);
    end
    step();
    u_if.tx_busy = 1'b0;
    rstn = 1'b1;
    step();
    n_tests++;
    if ({u_if.tx_start, u_if.grant_id, u_if.ack, u_if.tx_data} !== {1'b1, 2'd0, 4'b0001, 8'h11}) begin
      n_fail++; $display("FAIL rmid_regrant: got %h want %h", {u_if.tx_start, u_if.grant_id, u_if.ack, u_if.tx_data}, {1'b1, 2'd0, 4'b0001, 8'h11});
    end
    u_if.req = '0;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    int s;
    do_reset();
    u_if.din = 32'h7E00_0041;
    u_if.req = 4'b0001;
    step();
    n_tests++;
    if ({u_if.tx_start, u_if.grant_id} !== {1'b1, 2'd0}) begin
      n_fail++; $display("FAIL b2b_first: got %h want %h", {u_if.tx_start, u_if.grant_id}, {1'b1, 2'd0});
    end
    u_if.req = '0;
    u_if.tx_busy = 1'b1;
    step();
    step();
    u_if.req = 4'b1000;
    step();
    step();
    n_tests++;
    if ({u_if.tx_start, u_if.active} !== 2'b01) begin
      n_fail++; $display("FAIL b2b_holdoff: got %b want 01", {u_if.tx_start, u_if.active});
    end
    u_if.tx_busy = 1'b0;
    step();
    n_tests++;
    if ({u_if.tx_start, u_if.active} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_gap: got %b want 00", {u_if.tx_start, u_if.active});
    end
    step();
    n_tests++;
    if ({u_if.tx_start, u_if.grant_id, u_if.ack, u_if.tx_data} !== {1'b1, 2'd3, 4'b1000, 8'h7E}) begin
      n_fail++; $display("FAIL b2b_second: got %h want %h", {u_if.tx_start, u_if.grant_id, u_if.ack, u_if.tx_data}, {1'b1, 2'd3, 4'b1000, 8'h7E});
    end
    u_if.req = '0;
    serve_frame(2, s);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_busy_defer();
    test_timeout();
    test_lock();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
